serial_alu_unit: RTL and testbench
==================================

Name: serial_alu_unit

Overview:
- Multi-cycle, digit-serial execution unit that consumes the 3-bit ALUControl code produced by the ALU decoder.
- Sits on the datapath side of that control code for the low-area core variant.
- Accepts one operation per valid/ready handshake, processes DIGIT bits per cycle from LSB to MSB, then presents Result/Zero through an output valid/ready handshake.

Parameters:
- WIDTH, 32, operand/result width; must be a multiple of DIGIT.
- DIGIT, 4, bits processed per RUN cycle; must be ≥ 1.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  request carries a valid operation.
- in_ready  output  1  unit can accept a request.
- ALUControl  input  3  operation code: 000 add, 001 sub, 010 and, 011 or, 101 slt; others are reserved.
- SrcA  input  WIDTH  operand A.
- SrcB  input  WIDTH  operand B.
- out_valid  output  1  Result/Zero valid.
- out_ready  input  1  consumer accepts the result.
- Result  output  WIDTH  operation result.
- Zero  output  1  asserted when Result == 0.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (rst low, asynchronous):
  - state goes to IDLE.
  - in_ready=1, out_valid=0, busy=0, Result=0, Zero=1.
  - Internal operand, carry and digit counter registers are cleared.
  - Reset mid-RUN or mid-DONE abandons the operation with no output.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready at a clk edge:
    - latch SrcA, SrcB and ALUControl;
    - carry = 1 for sub/slt, else 0;
    - digit counter = 0;
    - go to RUN.
  - The inputs are sampled only at that edge.
- RUN:
  - in_ready=0.
  - Each cycle processes digit k (bits k*DIGIT+DIGIT-1 .. k*DIGIT):
    - add: A+B+carry.
    - sub/slt: A+~B+carry.
    - and: A&B.
    - or: A|B.
    - Reserved codes: the digit result is 0.
  - The digit result is shifted into the result register from the MSB end, and the carry is registered.
  - After WIDTH/DIGIT cycles, go to DONE.
- slt:
  - In the final digit, record sign S of the difference and the overflow V (carry into MSB XOR carry out of MSB).
  - Final Result = {WIDTH-1 zeros, S^V}, a signed compare.
- add/sub wrap modulo 2^WIDTH; carry out is discarded.
- Latency: exactly WIDTH/DIGIT cycles from the accept edge to out_valid=1 (8 cycles at the defaults).
- DONE:
  - out_valid=1; Result and Zero are stable.
  - Zero = (Result == 0), registered together with Result.
  - On out_ready=1 at the edge: go to IDLE, out_valid goes to 0, and Result/Zero hold their last value.
  - out_ready=0 holds DONE indefinitely (backpressure). in_valid is ignored.
- No pipelining: at most one operation in flight. in_ready returns to 1 one cycle after the output handshake; there is no same-cycle accept in DONE.
- out_ready asserted outside DONE has no effect.
- in_valid in RUN/DONE is not accepted. The requester holds the request until in_ready.
- DIGIT == WIDTH is legal: RUN lasts 1 cycle.

Optional Feature:
- Macro: SERIAL_ALU_XOR_EN.
- Defined: ALUControl 100 performs A^B digit-serially, with the same latency as and/or.
- Not defined: 100 is reserved and produces Result=0, Zero=1.
- All other behaviour is identical in both builds.

Test Plan:
- Reset mid-RUN:
  - Stimulus: assert rst low after 3 RUN cycles, then release.
  - Required: in_ready=1, out_valid=0, Result=0, Zero=1; the next request completes normally.
- add:
  - Stimulus: ALUControl=000, SrcA=0xFFFF_FFFF, SrcB=0x0000_0001, out_ready=1.
  - Required: out_valid 8 cycles after accept, Result=0x0000_0000, Zero=1 (wrap).
- sub with backpressure:
  - Stimulus: ALUControl=001, SrcA=0x0000_0005, SrcB=0x0000_0007; hold out_ready=0 for 5 cycles.
  - Required: Result=0xFFFF_FFFE, Zero=0, held stable with out_valid=1 until out_ready, and no new accept meanwhile.
- slt overflow:
  - Stimulus: ALUControl=101, SrcA=0x8000_0000, SrcB=0x0000_0001.
  - Required: Result=0x0000_0001.
  - Repeat with SrcA=0x7FFF_FFFF, SrcB=0x8000_0000; required Result=0x0000_0000, Zero=1.
- and/or:
  - Stimulus: ALUControl=010, then 011, with SrcA=0xF0F0_1234, SrcB=0x0FF0_FF00.
  - Required: 0x00F0_1200, then 0xFFF0_FF34.
- Reserved/optional code:
  - Stimulus: ALUControl=100, SrcA=0xAAAA_AAAA, SrcB=0xFFFF_0000.
  - Required with SERIAL_ALU_XOR_EN: Result=0x5555_AAAA. Without it: Result=0, Zero=1.
  - Also check in_valid held high during RUN is not double-accepted.

Source files
------------

// File: rtl/serial_alu_unit.sv
// Digit-serial ALU: DIGIT bits per cycle, LSB first, valid/ready in and out.
// Optional macro SERIAL_ALU_XOR_EN enables ALUControl 100 as A^B.
module serial_alu_unit #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       ALUControl,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic             busy
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2:0]         op_q, op_d;
    logic               carry_q, carry_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               zero_q, zero_d;

    logic               inv;
    logic [DIGIT-1:0]   a_dig, b_dig, bx, dig;
    logic [DIGIT:0]     sum;
    logic               msb_cin, ovf, lt;
    logic [WIDTH-1:0]   a_nx, b_nx;

    // Current digit operands; subtract paths add the inverted B digit.
    assign inv   = (op_q == OP_SUB) || (op_q == OP_SLT);
    assign a_dig = a_q[DIGIT-1:0];
    assign b_dig = b_q[DIGIT-1:0];
    assign bx    = inv ? ~b_dig : b_dig;
    assign sum   = {1'b0, a_dig} + {1'b0, bx} + {{DIGIT{1'b0}}, carry_q};

    // Signed compare from the top digit: sign of difference xor overflow.
    assign msb_cin = a_dig[DIGIT-1] ^ bx[DIGIT-1] ^ sum[DIGIT-1];
    assign ovf     = msb_cin ^ sum[DIGIT];
    assign lt      = sum[DIGIT-1] ^ ovf;

    // Digit result for the latched operation; unused codes yield zero.
    always_comb begin
        dig = '0;
        case (op_q)
            OP_ADD, OP_SUB, OP_SLT: dig = sum[DIGIT-1:0];
            OP_AND:                 dig = a_dig & b_dig;
            OP_OR:                  dig = a_dig | b_dig;
`ifdef SERIAL_ALU_XOR_EN
            OP_XOR:                 dig = a_dig ^ b_dig;
`endif
            default:                dig = '0;
        endcase
    end

    // A doubles as the result shifter: digits enter at the MSB end.
    generate
        if (DIGIT < WIDTH) begin : g_shift
            assign a_nx = {dig, a_q[WIDTH-1:DIGIT]};
            assign b_nx = {{DIGIT{1'b0}}, b_q[WIDTH-1:DIGIT]};
        end else begin : g_single
            assign a_nx = dig;
            assign b_nx = '0;
        end
    endgenerate

    // Next-state, operand shifting and final result capture.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        zero_d  = zero_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = SrcA;
                    b_d     = SrcB;
                    op_d    = ALUControl;
                    carry_d = (ALUControl == OP_SUB) ||
                              (ALUControl == OP_SLT);
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                a_d     = a_nx;
                b_d     = b_nx;
                carry_d = sum[DIGIT];
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    if (op_q == OP_SLT) begin
                        res_d    = '0;
                        res_d[0] = lt;
                    end else begin
                        res_d = a_nx;
                    end
                    zero_d  = ~|res_d;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any operation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
            zero_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q == S_RUN) || (state_q == S_DONE);
    assign Result    = res_q;
    assign Zero      = zero_q;

endmodule

// File: tb/tb_serial_alu_unit.sv
// Directed bench for serial_alu_unit at default WIDTH=32, DIGIT=4.
// Expected values are hand-computed; XOR expectation follows SERIAL_ALU_XOR_EN.
module tb_serial_alu_unit;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  ALUControl;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] Result;
    logic        Zero;
    logic        busy;

    int n_assert = 0;
    int n_fail   = 0;

    serial_alu_unit dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ALUControl (ALUControl),
        .SrcA       (SrcA),
        .SrcB       (SrcB),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .Result     (Result),
        .Zero       (Zero),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input logic expz,
                          input int stall, input bit hold);
        int n;
        @(negedge clk);
        in_valid   = 1'b1;
        ALUControl = op;
        SrcA       = a;
        SrcB       = b;
        out_ready  = (stall == 0);
        chk({tag, "/in_ready"}, in_ready, 1);
        @(posedge clk);
        #1;
        if (!hold) begin
            in_valid   = 1'b0;
            ALUControl = 3'b011;
            SrcA       = ~a;
            SrcB       = ~b;
        end
        chk({tag, "/busy_run"}, busy, 1);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "/latency"}, n, 8);
        chk({tag, "/out_valid"}, out_valid, 1);
        chk({tag, "/result"}, Result, exp);
        chk({tag, "/zero"}, Zero, expz);
        chk({tag, "/in_ready_done"}, in_ready, 0);
        if (stall > 0) begin
            repeat (stall) begin
                @(posedge clk);
                #1;
            end
            chk({tag, "/held_valid"}, out_valid, 1);
            chk({tag, "/held_result"}, Result, exp);
            chk({tag, "/held_zero"}, Zero, expz);
            chk({tag, "/held_no_accept"}, in_ready, 0);
            out_ready = 1'b1;
        end
        if (hold) in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, "/post_valid"}, out_valid, 0);
        chk({tag, "/post_ready"}, in_ready, 1);
        chk({tag, "/post_busy"}, busy, 0);
        chk({tag, "/post_result"}, Result, exp);
        chk({tag, "/post_zero"}, Zero, expz);
        if (hold) begin
            @(posedge clk);
            #1;
            chk({tag, "/no_double_accept"}, busy, 0);
        end
        out_ready = 1'b0;
    endtask

    logic [31:0] xor_exp;
    logic        xor_z;

    initial begin
        rst        = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        ALUControl = 3'b000;
        SrcA       = '0;
        SrcB       = '0;
        #12;
        chk("reset/in_ready", in_ready, 1);
        chk("reset/out_valid", out_valid, 0);
        chk("reset/busy", busy, 0);
        chk("reset/result", Result, 0);
        chk("reset/zero", Zero, 1);
        @(negedge clk);
        rst = 1'b1;

        // Reset after three RUN cycles
        @(negedge clk);
        in_valid   = 1'b1;
        ALUControl = 3'b000;
        SrcA       = 32'h0000_0001;
        SrcB       = 32'h0000_0002;
        out_ready  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("midrun/busy", busy, 1);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("midrun/in_ready", in_ready, 1);
        chk("midrun/out_valid", out_valid, 0);
        chk("midrun/busy", busy, 0);
        chk("midrun/result", Result, 0);
        chk("midrun/zero", Zero, 1);
        @(negedge clk);
        rst       = 1'b1;
        out_ready = 1'b0;

        run_op("add_wrap", 3'b000, 32'hFFFF_FFFF, 32'h0000_0001,
               32'h0000_0000, 1'b1, 0, 1'b0);
        run_op("sub_bp", 3'b001, 32'h0000_0005, 32'h0000_0007,
               32'hFFFF_FFFE, 1'b0, 5, 1'b0);
        run_op("slt_ovf1", 3'b101, 32'h8000_0000, 32'h0000_0001,
               32'h0000_0001, 1'b0, 0, 1'b0);
        run_op("slt_ovf2", 3'b101, 32'h7FFF_FFFF, 32'h8000_0000,
               32'h0000_0000, 1'b1, 0, 1'b0);
        run_op("and", 3'b010, 32'hF0F0_1234, 32'h0FF0_FF00,
               32'h00F0_1200, 1'b0, 0, 1'b0);
        run_op("or", 3'b011, 32'hF0F0_1234, 32'h0FF0_FF00,
               32'hFFF0_FF34, 1'b0, 2, 1'b0);
        run_op("add_plain", 3'b000, 32'h1234_5678, 32'h0FED_CBA8,
               32'h2222_2220, 1'b0, 0, 1'b1);
`ifdef SERIAL_ALU_XOR_EN
        xor_exp = 32'h5555_AAAA;
        xor_z   = 1'b0;
`else
        xor_exp = 32'h0000_0000;
        xor_z   = 1'b1;
`endif
        run_op("code100", 3'b100, 32'hAAAA_AAAA, 32'hFFFF_0000,
               xor_exp, xor_z, 0, 1'b1);
        run_op("slt_pos", 3'b101, 32'h0000_0003, 32'h0000_0009,
               32'h0000_0001, 1'b0, 0, 1'b1);
        run_op("code110", 3'b110, 32'hAAAA_AAAA, 32'hFFFF_0000,
               32'h0000_0000, 1'b1, 0, 1'b0);
        run_op("sub_zero", 3'b001, 32'h8765_4321, 32'h8765_4321,
               32'h0000_0000, 1'b1, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
